// File: rtl/map_writer.sv
// -----------------------------------------------------------------------------
// map_writer
// Builds an 8x8 wall/visited map while a robot walks the grid. Each accepted
// step strobe runs a fixed four-cycle sequence. The sequence moves the robot,
// marks the walls seen from the new cell, then mirrors each wall into the
// neighbouring cell on the far side of that wall.
//
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   step                  : one-cycle strobe, samples acao/orientacao/head/left
//   acao[2:0]             : 3'b001 = advance one cell, anything else = stay
//   orientacao[2:0]       : heading 0=N 1=E 2=S 3=W, 4..7 invalid
//   head, left            : wall ahead / wall on the left, seen after the move
//   rd_x, rd_y            : read address (column, row)
//   rd_walls, rd_visited  : registered read data (bit0 N, bit1 E, bit2 S, bit3 W)
//   pos_x, pos_y          : current robot cell
//   busy                  : a step sequence is in progress
//   visitados             : number of distinct visited cells (0..64)
//   err_borda             : sticky, a move would have left the grid
//   err_overrun           : sticky, a step arrived while busy and was dropped
//   err_orient            : sticky, a step carried an invalid heading
//
// state | meaning
// IDLE  | waiting for step
// MOVE  | advance pos toward the heading if commanded and on-grid
// MARK  | OR head/left walls into the current cell, set visited
// MIR_H | mirror the head wall into the cell ahead
// MIR_L | mirror the left wall into the cell to the left
// -----------------------------------------------------------------------------
module map_writer #(
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    input  logic [2:0] acao,
    input  logic [2:0] orientacao,
    input  logic       head,
    input  logic       left,
    input  logic [2:0] rd_x,
    input  logic [2:0] rd_y,
    output logic [3:0] rd_walls,
    output logic       rd_visited,
    output logic [2:0] pos_x,
    output logic [2:0] pos_y,
    output logic       busy,
    output logic [6:0] visitados,
    output logic       err_borda,
    output logic       err_overrun,
    output logic       err_orient
);

    typedef enum logic [2:0] {IDLE, MOVE, MARK, MIR_H, MIR_L} state_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] x;
        logic [2:0] y;
    } cell_t;

    // Neighbour of (x,y) in direction d; ok=0 when it falls off the grid.
    function automatic cell_t neighbour(input logic [2:0] x, input logic [2:0] y,
                                        input logic [1:0] d);
        cell_t c;
        c.ok = 1'b1;
        c.x  = x;
        c.y  = y;
        case (d)
            2'd0: if (y == 3'd7) c.ok = 1'b0; else c.y = y + 3'd1;
            2'd1: if (x == 3'd7) c.ok = 1'b0; else c.x = x + 3'd1;
            2'd2: if (y == 3'd0) c.ok = 1'b0; else c.y = y - 3'd1;
            default: if (x == 3'd0) c.ok = 1'b0; else c.x = x - 3'd1;
        endcase
        return c;
    endfunction

    state_t      state;
    logic [3:0]  walls [64];
    logic [63:0] visited;

    logic [2:0]  acao_q;
    logic [2:0]  ori_q;
    logic        head_q;
    logic        left_q;

    logic        ori_valid;
    logic [1:0]  dir;
    logic [1:0]  dir_left;
    logic [5:0]  cur_idx;
    cell_t       ahead;
    cell_t       lside;

    assign ori_valid = ~ori_q[2];
    assign dir       = ori_q[1:0];
    assign dir_left  = dir + 2'd3;
    assign cur_idx   = {pos_y, pos_x};
    // Neighbours are taken from the post-move position, so MIR_* see the new cell.
    assign ahead     = neighbour(pos_x, pos_y, dir);
    assign lside     = neighbour(pos_x, pos_y, dir_left);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pos_x       <= 3'(START_X);
            pos_y       <= 3'(START_Y);
            visited     <= '0;
            visitados   <= '0;
            err_borda   <= 1'b0;
            err_overrun <= 1'b0;
            err_orient  <= 1'b0;
            rd_walls    <= '0;
            rd_visited  <= 1'b0;
            acao_q      <= '0;
            ori_q       <= '0;
            head_q      <= 1'b0;
            left_q      <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                walls[i] <= '0;
            end
        end else begin
            // Nonblocking read returns the pre-write value on a same-cycle write.
            rd_walls   <= walls[{rd_y, rd_x}];
            rd_visited <= visited[{rd_y, rd_x}];

            if (step && busy) begin
                err_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (step) begin
                        acao_q <= acao;
                        ori_q  <= orientacao;
                        head_q <= head;
                        left_q <= left;
                        busy   <= 1'b1;
                        state  <= MOVE;
                    end
                end
                MOVE: begin
                    if (!ori_valid) begin
                        err_orient <= 1'b1;
                    end else if (acao_q == 3'b001) begin
                        if (ahead.ok) begin
                            pos_x <= ahead.x;
                            pos_y <= ahead.y;
                        end else begin
                            err_borda <= 1'b1;
                        end
                    end
                    state <= MARK;
                end
                MARK: begin
                    if (ori_valid) begin
                        walls[cur_idx] <= walls[cur_idx]
                                        | (head_q ? (4'b0001 << dir) : 4'b0000)
                                        | (left_q ? (4'b0001 << dir_left) : 4'b0000);
                        visited[cur_idx] <= 1'b1;
                        if (!visited[cur_idx] && visitados != 7'd64) begin
                            visitados <= visitados + 7'd1;
                        end
                    end
                    state <= MIR_H;
                end
                MIR_H: begin
                    if (ori_valid && head_q && ahead.ok) begin
                        walls[{ahead.y, ahead.x}] <= walls[{ahead.y, ahead.x}]
                                                   | (4'b0001 << (dir + 2'd2));
                    end
                    state <= MIR_L;
                end
                MIR_L: begin
                    if (ori_valid && left_q && lside.ok) begin
                        walls[{lside.y, lside.x}] <= walls[{lside.y, lside.x}]
                                                   | (4'b0001 << (dir + 2'd1));
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_writer.sv
// -----------------------------------------------------------------------------
// tb_map_writer
// Directed bench for map_writer. A behavioural grid model predicts the result
// of every step; predictions go into a scoreboard queue when stimulus is driven
// and are popped against DUT outputs once the DUT has produced them.
// -----------------------------------------------------------------------------
module tb_map_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic       step;
    logic [2:0] acao;
    logic [2:0] orientacao;
    logic       head;
    logic       left;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [3:0] rd_walls;
    logic       rd_visited;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic       busy;
    logic [6:0] visitados;
    logic       err_borda;
    logic       err_overrun;
    logic       err_orient;

    map_writer dut (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .acao       (acao),
        .orientacao (orientacao),
        .head       (head),
        .left       (left),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_walls   (rd_walls),
        .rd_visited (rd_visited),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .visitados  (visitados),
        .err_borda  (err_borda),
        .err_overrun(err_overrun),
        .err_orient (err_orient)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference model: plain integer grid, heading deltas from a table.
    int mw [64];
    int mv [64];
    int mx, my, mcnt, meb, meo, mer;
    int dx [4] = '{0, 1, 0, -1};
    int dy [4] = '{1, 0, -1, 0};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = 32'(v);
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %0d required nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic bit on_grid(input int x, input int y);
        return (x >= 0) && (x < 8) && (y >= 0) && (y < 8);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mw[i] = 0;
            mv[i] = 0;
        end
        mx = 0; my = 0; mcnt = 0; meb = 0; meo = 0; mer = 0;
    endtask

    task automatic model_step(input int a, input int o, input int h, input int l);
        int d, nx, ny, c, ld;
        if (o > 3) begin
            meo = 1;
        end else begin
            d = o;
            if (a == 1) begin
                nx = mx + dx[d];
                ny = my + dy[d];
                if (on_grid(nx, ny)) begin
                    mx = nx;
                    my = ny;
                end else begin
                    meb = 1;
                end
            end
            c = my * 8 + mx;
            if (h != 0) mw[c] = mw[c] | (1 << d);
            if (l != 0) mw[c] = mw[c] | (1 << ((d + 3) % 4));
            if (mv[c] == 0) begin
                mv[c] = 1;
                if (mcnt < 64) mcnt++;
            end
            if (h != 0) begin
                nx = mx + dx[d];
                ny = my + dy[d];
                if (on_grid(nx, ny)) mw[ny * 8 + nx] = mw[ny * 8 + nx] | (1 << ((d + 2) % 4));
            end
            if (l != 0) begin
                ld = (d + 3) % 4;
                nx = mx + dx[ld];
                ny = my + dy[ld];
                if (on_grid(nx, ny)) mw[ny * 8 + nx] = mw[ny * 8 + nx] | (1 << ((d + 1) % 4));
            end
        end
    endtask

    task automatic push_status();
        expect_val("busy", 0);
        expect_val("pos_x", mx);
        expect_val("pos_y", my);
        expect_val("visitados", mcnt);
        expect_val("err_borda", meb);
        expect_val("err_overrun", mer);
        expect_val("err_orient", meo);
    endtask

    task automatic check_status();
        check(32'(busy));
        check(32'(pos_x));
        check(32'(pos_y));
        check(32'(visitados));
        check(32'(err_borda));
        check(32'(err_overrun));
        check(32'(err_orient));
    endtask

    task automatic drive_step(input int a, input int o, input int h, input int l);
        step       = 1'b1;
        acao       = 3'(a);
        orientacao = 3'(o);
        head       = h[0];
        left       = l[0];
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 12) begin
            n++;
            tick();
        end
    endtask

    // Full step: checks busy lasts exactly four sampled cycles, then status.
    task automatic do_step(input int a, input int o, input int h, input int l);
        int n;
        model_step(a, o, h, l);
        expect_val("busy_cycles", 4);
        push_status();
        drive_step(a, o, h, l);
        tick();
        step = 1'b0;
        wait_idle(n);
        check(32'(n));
        check_status();
    endtask

    task automatic read_cell(input int x, input int y);
        expect_val($sformatf("walls(%0d,%0d)", x, y), mw[y * 8 + x]);
        expect_val($sformatf("visited(%0d,%0d)", x, y), mv[y * 8 + x]);
        rd_x = 3'(x);
        rd_y = 3'(y);
        tick();
        check(32'(rd_walls));
        check(32'(rd_visited));
    endtask

    initial begin
        int n;
        reset = 1'b1; step = 1'b0; acao = '0; orientacao = '0;
        head = 1'b0; left = 1'b0; rd_x = '0; rd_y = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Reset state: start cell not yet visited.
        push_status();
        check_status();
        read_cell(0, 0);

        // North with a wall ahead: wall in (0,1), mirrored into (0,2).
        do_step(1, 0, 1, 0);
        read_cell(0, 1);
        read_cell(0, 2);
        read_cell(0, 0);

        // Back south to (0,0), then bump the south border with a wall ahead.
        do_step(1, 2, 0, 0);
        begin
            int pw, pv;
            pw = mw[0];
            pv = mv[0];
            model_step(1, 2, 1, 0);
            expect_val("prewrite_walls", pw);
            expect_val("prewrite_visited", pv);
            push_status();
            rd_x = 3'd0;
            rd_y = 3'd0;
            drive_step(1, 2, 1, 0);
            tick();
            step = 1'b0;
            tick();
            tick();
            // Read register sampled on the same edge as the MARK write.
            check(32'(rd_walls));
            check(32'(rd_visited));
            wait_idle(n);
            check_status();
        end
        read_cell(0, 0);
        read_cell(0, 1);

        // Walk to (3,3), then stand facing east with walls ahead and left.
        for (int i = 0; i < 3; i++) do_step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) do_step(1, 0, 0, 0);
        do_step(0, 1, 1, 1);
        read_cell(3, 3);
        read_cell(4, 3);
        read_cell(3, 4);
        do_step(0, 1, 1, 1);
        read_cell(3, 3);

        // Invalid heading: no move, no writes, err_orient, still four busy cycles.
        do_step(1, 5, 1, 1);
        read_cell(3, 3);
        read_cell(4, 3);

        // Second strobe two cycles into a step is dropped.
        model_step(1, 3, 0, 0);
        mer = 1;
        push_status();
        drive_step(1, 3, 0, 0);
        tick();
        step = 1'b0;
        tick();
        drive_step(1, 0, 1, 1);
        tick();
        step = 1'b0;
        wait_idle(n);
        check_status();
        read_cell(2, 3);
        // A step once idle is accepted again.
        do_step(1, 0, 0, 1);
        read_cell(1, 4);

        // Reset while in MARK aborts the step and clears everything.
        drive_step(1, 1, 1, 1);
        tick();
        step = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        push_status();
        check_status();
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                read_cell(x, y);
            end
        end

        // First step after reset marks the start cell.
        do_step(0, 0, 0, 0);
        read_cell(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/map_writer.md
MAP_WRITER -- requirements
Module: map_writer

Interface
REQ-001 Parameter START_X, default 0, initial robot column (0..7).
REQ-002 Parameter START_Y, default 0, initial robot row (0..7).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clock  in  1  system clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 step  in  1  one-cycle strobe; acao/orientacao/head/left valid this cycle.
REQ-007 acao  in  3  movement command; 3'b001 = advance one cell, any other value = no move.
REQ-008 orientacao  in  3  heading; 0=N, 1=E, 2=S, 3=W, 4..7 invalid.
REQ-009 head  in  1  1 = wall ahead, after the move.
REQ-010 left  in  1  1 = wall on the left, after the move.
REQ-011 rd_x, rd_y  in  3 each  read address (column, row).
REQ-012 rd_walls  out  4  wall bits of addressed cell; bit0 N, bit1 E, bit2 S, bit3 W.
REQ-013 rd_visited  out  1  visited bit of addressed cell.
REQ-014 pos_x, pos_y  out  3 each  current robot cell.
REQ-015 busy  out  1  step in progress.
REQ-016 visitados  out  7  count of visited cells (0..64).
REQ-017 err_borda, err_overrun, err_orient  out  1 each  sticky error flags.

Function
REQ-018 The grid SHALL be 8x8 cells; N increments y, E increments x; each cell SHALL store 4 wall bits and 1 visited bit in flops.
REQ-019 FSM states SHALL be IDLE, MOVE, MARK, MIR_H, MIR_L; the sequence is IDLE->MOVE->MARK->MIR_H->MIR_L->IDLE, one cycle each, unconditionally.
REQ-020 step=1 in IDLE at cycle T SHALL latch all inputs, enter MOVE at T+1, and return to IDLE at T+5; busy=1 for cycles T+1..T+4 only.
REQ-021 step=1 while busy=1 SHALL be dropped and set err_overrun.
REQ-022 MOVE: if acao=3'b001 and orientacao valid, pos SHALL move one cell toward orientacao.
REQ-023 If the move leaves the grid, pos SHALL be unchanged, err_borda set, and the remaining states SHALL proceed normally.
REQ-024 MARK: current cell SHALL OR in bit[orientacao] if head=1 and bit[(orientacao+3) mod 4] if left=1, and set visited.
REQ-025 visitados SHALL increment in MARK only on a 0->1 visited transition, saturating at 64.
REQ-026 MIR_H: if head=1 and the ahead neighbour is on-grid, that neighbour SHALL OR in the opposite bit ((orientacao+2) mod 4); if off-grid, no write.
REQ-027 MIR_L: the same rule SHALL apply for the left neighbour, using bit ((orientacao+1) mod 4).
REQ-028 Wall bits SHALL be sticky; only reset clears them.
REQ-029 orientacao 4..7 SHALL cause no move, no wall/visited/count writes, and set err_orient; the FSM still takes 4 busy cycles.
REQ-030 rd_walls/rd_visited SHALL be registered, with 1-cycle latency from rd_x/rd_y.
REQ-031 A read and a write to the same cell in the same cycle SHALL return the pre-write value.

Reset
REQ-032 reset=1 at any edge, including mid-step, SHALL force IDLE and take priority over step.
REQ-033 On that edge, reset SHALL set pos to (START_X,START_Y), clear all 64 cells, and clear visitados, busy, all err flags, rd_walls and rd_visited.
REQ-034 The start cell SHALL not be marked visited until the first completed MARK.

Verification
REQ-035 After reset, step with acao=001, orientacao=0, head=1, left=0 -> pos=(0,1); cell(0,1) walls=4'b0001; cell(0,2) walls=4'b0100; visitados=1; busy high exactly 4 cycles.
REQ-036 At (0,0), step with acao=001, orientacao=2 (S) -> pos stays (0,0), err_borda=1; with head=1, cell(0,0) bit2 set; no mirror write.
REQ-037 Facing E at (3,3), acao=000, head=1, left=1 -> cell(3,3) walls=4'b0011, cell(4,3) bit3=1, cell(3,4) bit2=1; a second identical step leaves visitados unchanged.
REQ-038 A second step 2 cycles after the first -> dropped, err_overrun=1; a step at busy=0 is accepted.
REQ-039 Assert reset during MARK -> next cycle busy=0, pos=(START_X,START_Y), all rd_walls=0, visitados=0.
REQ-040 orientacao=5 with acao=001 -> no pos change, no memory change, err_orient=1; busy high 4 cycles.
